// File: rtl/sub_128bit_serial.sv
// Bit-serial 128-bit subtractor: one 5-bit slice per cycle over 130-bit
// zero-extended operands, with the borrow taken from result bit 128.
module sub_128bit_serial (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         busy,
    output logic         done,
    output logic [127:0] d,
    output logic         borrow
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [4:0] LAST_SLICE = 5'd25;

    state_t       state_q, state_d;
    logic [129:0] a_q, a_d;
    logic [129:0] b_q, b_d;
    logic [129:0] res_q, res_d;
    logic [4:0]   idx_q, idx_d;
    logic         carry_q, carry_d;
    logic [127:0] d_q, d_d;
    logic         borrow_q, borrow_d;
    logic [7:0]   base;
    logic [5:0]   sum;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        base     = {3'b000, idx_q} * 8'd5;
        sum      = {1'b0, a_q[base +: 5]} + {1'b0, ~b_q[base +: 5]} + {5'b00000, carry_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = {2'b00, a};
                    b_d     = {2'b00, b};
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: 5] = sum[4:0];
                carry_d          = sum[5];
                idx_d            = idx_q + 5'd1;
                // Outputs load from the just-completed result so they change only on entry to DONE.
                if (idx_q == LAST_SLICE) begin
                    d_d      = res_d[127:0];
                    borrow_d = res_d[128];
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            d_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign d      = d_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_128bit_serial.sv
// Scoreboard bench for sub_128bit_serial: expected {borrow, d} queued at start,
// popped and compared by a negedge monitor on every done pulse.
module tb_sub_128bit_serial;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] a = '0;
    logic [127:0] b = '0;
    logic         busy;
    logic         done;
    logic [127:0] d;
    logic         borrow;

    int unsigned  checks = 0;
    int unsigned  failures = 0;
    logic [128:0] sb[$];
    logic [128:0] exp_v;
    logic [128:0] last_out = '0;
    logic         done_prev = 1'b0;
    int unsigned  busy_run = 0;

    always #5 clk = ~clk;

    sub_128bit_serial dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .borrow (borrow)
    );

    task automatic check_eq(input string tag, input logic [131:0] got, input logic [131:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor: reset values, result scoreboard, busy length, output hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_outputs", {busy, done, borrow, d}, '0);
            last_out  = '0;
            done_prev = 1'b0;
            busy_run  = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check_eq("done_single", done_prev, 0);
                check_eq("busy_len", busy_run, 26);
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", done, 0);
                end else begin
                    exp_v = sb.pop_front();
                    check_eq("result", {borrow, d}, exp_v);
                end
                busy_run = 0;
                last_out = {borrow, d};
            end else begin
                check_eq("hold", {borrow, d}, last_out);
            end
            check_eq("busy_done_excl", busy & done, 0);
            done_prev = done;
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("idle_timeout", busy | done, 0);
    endtask

    task automatic run_op(input logic [127:0] av, input logic [127:0] bv, input bit noise);
        int unsigned n;
        wait_idle();
        a     = av;
        b     = bv;
        start = 1'b1;
        sb.push_back({(av < bv), av - bv});
        @(negedge clk);
        start = 1'b0;
        if (noise) begin
            a = 128'd100;
            b = 128'd1;
        end else begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
        end
        check_eq("accept_busy", busy, 1);
        n = 1;
        while (!done && n < 40) begin
            start = noise && (n == 6);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_eq("latency", n, 27);
        if (noise) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] p127;
        logic [127:0] ra, rb;
        p127 = '0;
        p127[127] = 1'b1;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(128'd5, 128'd1, 1'b0);
        run_op(128'd0, 128'd1, 1'b0);
        run_op(128'h8000_0000_0000_0000_0000_0000_0000_0001,
               128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0);
        run_op(p127, p127 - 128'd1, 1'b0);

        run_op(128'd10, 128'd3, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("ignored_start_busy", busy, 0);
        check_eq("held_d", {borrow, d}, {1'b0, 128'd7});
        run_op(128'd1000, 128'd1000, 1'b0);

        // Abort a run mid-way; reset must clear outputs without waiting for a clock.
        wait_idle();
        a     = 128'd77;
        b     = 128'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst", {busy, done, borrow, d}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(128'd1, 128'd2, 1'b0);
        check_eq("post_rst_d", {borrow, d}, {1'b1, {128{1'b1}}});

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 9))
                0: rb = ra;
                1: rb = ra + 128'd1;
                2: ra = rb + 128'd1;
                default: ;
            endcase
            run_op(ra, rb, 1'b0);
        end

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
